// File: rtl/branch_cond_unit.sv
// Branch condition resolver: latches one branch request, waits for in-flight
// flag updates, evaluates the condition and issues PC load/flush. Optional counters: BRANCH_STATS_EN.
module branch_cond_unit #(
  parameter int ADDR_W = 8
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] target,
  input  logic              flags_pending,
  input  logic              Z,
  input  logic              N,
  input  logic              V,
  input  logic              C,
  output logic              busy,
  output logic              decided,
  output logic              taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic cond_true(input logic [3:0] cc, input logic z, input logic n,
                                     input logic v, input logic c);
    logic r;
    case (cc)
      4'd0:    r = 1'b1;
      4'd1:    r = z;
      4'd2:    r = ~z;
      4'd3:    r = ~z & (n == v);
      4'd4:    r = (n == v);
      4'd5:    r = (n != v);
      4'd6:    r = z | (n != v);
      4'd7:    r = c;
      4'd8:    r = ~c;
      4'd9:    r = v;
      4'd10:   r = ~v;
      4'd11:   r = n;
      4'd12:   r = ~n;
      4'd13:   r = c & ~z;
      4'd14:   r = ~c | z;
      4'd15:   r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                busy_q, busy_d;
  logic                decided_q, decided_d;
  logic                taken_q, taken_d;
  logic                pc_load_q, pc_load_d;
  logic                flush_q, flush_d;
  logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
  logic                hit_s;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    target_d    = target_q;
    decided_d   = 1'b0;
    taken_d     = 1'b0;
    pc_load_d   = 1'b0;
    flush_d     = 1'b0;
    pc_target_d = {ADDR_W{1'b0}};
    hit_s       = cond_true(cond_q, Z, N, V, C);
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_EVAL;
          cond_d   = cond;
          target_d = target;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EVAL: begin
        // Flags still in flight: hold without deciding
        if (flags_pending) begin
          state_d = S_EVAL;
        end else begin
          decided_d = 1'b1;
          if (hit_s) begin
            taken_d     = 1'b1;
            pc_load_d   = 1'b1;
            flush_d     = 1'b1;
            pc_target_d = target_q;
            state_d     = S_FLUSH;
          end else begin
            state_d     = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, latched request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cond_q      <= 4'd0;
      target_q    <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      decided_q   <= 1'b0;
      taken_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      busy_q      <= busy_d;
      decided_q   <= decided_d;
      taken_q     <= taken_d;
      pc_load_q   <= pc_load_d;
      flush_q     <= flush_d;
      pc_target_q <= pc_target_d;
    end
  end

  assign busy      = busy_q;
  assign decided   = decided_q;
  assign taken     = taken_q;
  assign pc_load   = pc_load_q;
  assign flush     = flush_q;
  assign pc_target = pc_target_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  // Saturating counters, updated on the same edge that registers the decision
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (decided_d && taken_d && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
    if (decided_d && !taken_d && (nottaken_cnt_q != {CNT_W{1'b1}})) begin
      nottaken_cnt_d = nottaken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      nottaken_cnt_d = nottaken_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q    <= {CNT_W{1'b0}};
      nottaken_cnt_q <= {CNT_W{1'b0}};
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule
